// File: rtl/id_pkg.sv
// Shared definitions for the instruction-decode stage: opcodes, ALU operation
// codes, immediate formats, the registered decode packet and decode helpers.
// Imported by id_regfile users and id_decode_stage.
package id_pkg;

  localparam int XLEN_P = 32;
  localparam int ALU_W  = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [ALU_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALU_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALU_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALU_W-1:0] ALU_SLL  = 4'd5;
  localparam logic [ALU_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_W-1:0] ALU_SLT  = 4'd8;
  localparam logic [ALU_W-1:0] ALU_SLTU = 4'd9;

  typedef enum logic [1:0] {IMM_NONE, IMM_I, IMM_S, IMM_B} imm_fmt_e;

  typedef struct packed {
    logic              valid;
    logic [XLEN_P-1:0] pc;
    logic [XLEN_P-1:0] rs1_data;
    logic [XLEN_P-1:0] rs2_data;
    logic [XLEN_P-1:0] imm;
    logic [4:0]        rd;
    logic [2:0]        funct3;
    logic [ALU_W-1:0]  alu_op;
    logic              alu_src_imm;
    logic              reg_wr;
    logic              mem_rd;
    logic              mem_wr;
    logic              branch;
    logic              illegal;
  } pkt_t;

  // Sign-extended immediate for the given instruction format.
  function automatic logic [XLEN_P-1:0] imm_gen(input logic [31:0] instr,
                                                input imm_fmt_e    fmt);
    logic [XLEN_P-1:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // funct3 -> ALU op. alt is instr[30]; it picks SUB only for register-register
  // adds (ADDI has no subtract form) and SRA/SRAI for right shifts.
  function automatic logic [ALU_W-1:0] alu_from_funct3(input logic [2:0] f3,
                                                       input logic       alt,
                                                       input logic       is_r);
    logic [ALU_W-1:0] op;
    case (f3)
      3'b000:  op = (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Architectural register file: 2 combinational read ports, 1 write port, x0 hardwired to zero.
// Latency: reads are combinational with write-through bypass; writes land on the rising edge.
// Backpressure: none; a write is accepted every cycle.
// Ports: clk/rst (async active-high clear), we/waddr/wdata write port,
//        raddr1/rdata1 and raddr2/rdata2 read ports.
module id_regfile #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];

  always_comb begin
    mem_d = mem_q;
    if (we && (waddr != '0)) mem_d[waddr] = wdata;
    mem_d[0] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end

  // Bypass lets an instruction decoded in the same cycle as its producer's
  // writeback see the new value without an extra stall.
  always_comb begin
    if (raddr1 == '0)                      rdata1 = '0;
    else if (we && (waddr == raddr1))      rdata1 = wdata;
    else                                   rdata1 = mem_q[raddr1];
  end

  always_comb begin
    if (raddr2 == '0)                      rdata2 = '0;
    else if (we && (waddr == raddr2))      rdata2 = wdata;
    else                                   rdata2 = mem_q[raddr2];
  end

endmodule

// File: rtl/id_decode_stage.sv
// Instruction-decode stage: RV32I-subset decode, register-file read, load-use hazard detection.
// Latency: one cycle from if_* to the registered id_* packet.
// Backpressure: if_stall (combinational) holds fetch on a load-use hazard or while EX refuses a
//   valid packet; flush drops the packet and releases the stall.
// Ports: if_* fetch input, ex_ready/ex_is_load/ex_rd from execute, flush redirect,
//        wb_* register writeback, id_* registered decode packet towards execute.
module id_decode_stage
  import id_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int ALUOPW = ALU_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  input  logic [XLEN-1:0]   if_pc,
  output logic              if_stall,
  input  logic              ex_ready,
  input  logic              ex_is_load,
  input  logic [4:0]        ex_rd,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              id_valid,
  output logic [XLEN-1:0]   id_pc,
  output logic [XLEN-1:0]   id_rs1_data,
  output logic [XLEN-1:0]   id_rs2_data,
  output logic [XLEN-1:0]   id_imm,
  output logic [4:0]        id_rd,
  output logic [2:0]        id_funct3,
  output logic [ALUOPW-1:0] id_alu_op,
  output logic              id_alu_src_imm,
  output logic              id_reg_wr,
  output logic              id_mem_rd,
  output logic              id_mem_wr,
  output logic              id_branch,
  output logic              id_illegal
);

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;

  assign opcode = if_instr[6:0];
  assign rd     = if_instr[11:7];
  assign funct3 = if_instr[14:12];
  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];

  logic [XLEN-1:0] rs1_data, rs2_data;

  id_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_we),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  // ---------------- decode ----------------
  pkt_t     dec;
  imm_fmt_e imm_fmt;
  logic     rs1_used, rs2_used;

  always_comb begin
    dec         = '0;
    imm_fmt     = IMM_NONE;
    rs1_used    = 1'b0;
    rs2_used    = 1'b0;
    dec.pc      = if_pc;
    dec.rs1_data = rs1_data;
    dec.rs2_data = rs2_data;
    dec.rd      = rd;
    dec.funct3  = funct3;
    dec.alu_op  = ALU_ADD;
    case (opcode)
      OP_R: begin
        dec.alu_op = alu_from_funct3(funct3, if_instr[30], 1'b1);
        dec.reg_wr = 1'b1;
        rs1_used   = 1'b1;
        rs2_used   = 1'b1;
      end
      OP_IMM: begin
        dec.alu_op      = alu_from_funct3(funct3, if_instr[30], 1'b0);
        dec.alu_src_imm = 1'b1;
        dec.reg_wr      = 1'b1;
        imm_fmt         = IMM_I;
        rs1_used        = 1'b1;
      end
      OP_LOAD: begin
        dec.alu_src_imm = 1'b1;
        dec.reg_wr      = 1'b1;
        dec.mem_rd      = 1'b1;
        imm_fmt         = IMM_I;
        rs1_used        = 1'b1;
      end
      OP_STORE: begin
        dec.alu_src_imm = 1'b1;
        dec.mem_wr      = 1'b1;
        imm_fmt         = IMM_S;
        rs1_used        = 1'b1;
        rs2_used        = 1'b1;
      end
      OP_BRANCH: begin
        dec.alu_op = ALU_SUB;
        dec.branch = 1'b1;
        imm_fmt    = IMM_B;
        rs1_used   = 1'b1;
        rs2_used   = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.imm = imm_gen(if_instr, imm_fmt);
    // Writes to x0 are architectural no-ops; drop them here so EX/WB never see them.
    if (rd == 5'd0) dec.reg_wr = 1'b0;
  end

  // ---------------- hazard / stall ----------------
  logic hz;
  pkt_t pkt_q, pkt_d;

  assign hz = if_valid && ex_is_load && (ex_rd != 5'd0) &&
              (((ex_rd == rs1) && rs1_used) || ((ex_rd == rs2) && rs2_used));

  assign if_stall = !rst && !flush && (hz || (pkt_q.valid && !ex_ready));

  // ---------------- pipeline register ----------------
  always_comb begin
    pkt_d = pkt_q;
    if (flush) begin
      pkt_d.valid = 1'b0;
    end else if (pkt_q.valid && !ex_ready) begin
      pkt_d = pkt_q;
    end else if (hz) begin
      pkt_d.valid = 1'b0;
    end else begin
      pkt_d       = dec;
      pkt_d.valid = if_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pkt_q <= '0;
    else     pkt_q <= pkt_d;
  end

  assign id_valid       = pkt_q.valid;
  assign id_pc          = pkt_q.pc;
  assign id_rs1_data    = pkt_q.rs1_data;
  assign id_rs2_data    = pkt_q.rs2_data;
  assign id_imm         = pkt_q.imm;
  assign id_rd          = pkt_q.rd;
  assign id_funct3      = pkt_q.funct3;
  assign id_alu_op      = pkt_q.alu_op;
  assign id_alu_src_imm = pkt_q.alu_src_imm;
  assign id_reg_wr      = pkt_q.reg_wr;
  assign id_mem_rd      = pkt_q.mem_rd;
  assign id_mem_wr      = pkt_q.mem_wr;
  assign id_branch      = pkt_q.branch;
  assign id_illegal     = pkt_q.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: directed steps followed by constrained-random traffic,
// all checked against a behavioural model of the decode stage.
module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_stall;
  logic        ex_ready;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rd;
  logic [2:0]  id_funct3;
  logic [3:0]  id_alu_op;
  logic        id_alu_src_imm, id_reg_wr, id_mem_rd, id_mem_wr, id_branch, id_illegal;

  always #5 clk = ~clk;

  id_decode_stage dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_stall(if_stall),
    .ex_ready(ex_ready), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .flush(flush),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rd(id_rd), .id_funct3(id_funct3), .id_alu_op(id_alu_op),
    .id_alu_src_imm(id_alu_src_imm), .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd),
    .id_mem_wr(id_mem_wr), .id_branch(id_branch), .id_illegal(id_illegal)
  );

  typedef struct {
    bit          valid;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [3:0]  alu;
    bit          src, wr, mrd, mwr, br, ill;
  } model_pkt_t;

  model_pkt_t  m;
  logic [31:0] rf [32];
  // ALU codes indexed by funct3 for the non-alternate encodings.
  logic [3:0]  f3_ops [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
  logic [6:0]  illegal_ops [4] = '{7'b0110111, 7'b1101111, 7'b0001111, 7'b0000110};
  int          vectors = 0;
  int          miscompares = 0;
  bit          last_stall = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m = '{default: 0};
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
  endtask

  function automatic logic [31:0] rd_reg(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_we && wb_rd == r) return wb_data;
    return rf[r];
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
           op == 7'b0100011 || op == 7'b1100011;
  endfunction

  function automatic model_pkt_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    model_pkt_t p;
    int s, hi;
    logic [2:0] f3;
    p = '{default: 0};
    s = int'(ins);
    f3 = ins[14:12];
    p.pc = pc;
    p.rd = ins[11:7];
    p.f3 = f3;
    p.a = rd_reg(ins[19:15]);
    p.b = rd_reg(ins[24:20]);
    case (ins[6:0])
      7'b0110011: begin
        p.alu = f3_ops[f3];
        if (ins[30] && f3 == 3'd0) p.alu = 4'd1;
        if (ins[30] && f3 == 3'd5) p.alu = 4'd7;
        p.wr = 1;
      end
      7'b0010011: begin
        p.alu = f3_ops[f3];
        if (ins[30] && f3 == 3'd5) p.alu = 4'd7;
        p.src = 1; p.wr = 1;
        hi = s >>> 20; p.imm = hi;
      end
      7'b0000011: begin
        p.src = 1; p.wr = 1; p.mrd = 1;
        hi = s >>> 20; p.imm = hi;
      end
      7'b0100011: begin
        p.src = 1; p.mwr = 1;
        hi = s >>> 25; p.imm = hi * 32 + 32'(ins[11:7]);
      end
      7'b1100011: begin
        p.alu = 4'd1; p.br = 1;
        hi = s >>> 31;
        p.imm = hi * 4096 + 32'(ins[7]) * 2048 + 32'(ins[30:25]) * 32 + 32'(ins[11:8]) * 2;
      end
      default: p.ill = 1;
    endcase
    if (p.rd == 5'd0) p.wr = 0;
    return p;
  endfunction

  task automatic check_pkt(input string tag);
    chk({tag, ".valid"}, 32'(id_valid), 32'(m.valid));
    chk({tag, ".pc"}, id_pc, m.pc);
    chk({tag, ".rs1"}, id_rs1_data, m.a);
    chk({tag, ".rs2"}, id_rs2_data, m.b);
    chk({tag, ".imm"}, id_imm, m.imm);
    chk({tag, ".rd"}, 32'(id_rd), 32'(m.rd));
    chk({tag, ".f3"}, 32'(id_funct3), 32'(m.f3));
    chk({tag, ".alu"}, 32'(id_alu_op), 32'(m.alu));
    chk({tag, ".src"}, 32'(id_alu_src_imm), 32'(m.src));
    chk({tag, ".wr"}, 32'(id_reg_wr), 32'(m.wr));
    chk({tag, ".mrd"}, 32'(id_mem_rd), 32'(m.mrd));
    chk({tag, ".mwr"}, 32'(id_mem_wr), 32'(m.mwr));
    chk({tag, ".br"}, 32'(id_branch), 32'(m.br));
    chk({tag, ".ill"}, 32'(id_illegal), 32'(m.ill));
  endtask

  // Inputs are applied just after a falling edge; check the stall, advance the
  // model across the next rising edge and compare the new packet.
  task automatic step(input string tag);
    model_pkt_t nxt;
    logic [4:0] r1, r2;
    bit legal, u2, hz, stall;
    #1;
    r1 = if_instr[19:15];
    r2 = if_instr[24:20];
    legal = is_legal(if_instr[6:0]);
    u2 = if_instr[6:0] == 7'b0110011 || if_instr[6:0] == 7'b0100011 ||
         if_instr[6:0] == 7'b1100011;
    hz = if_valid && ex_is_load && ex_rd != 5'd0 &&
         ((ex_rd == r1 && legal) || (ex_rd == r2 && u2));
    stall = !flush && (hz || (m.valid && !ex_ready));
    chk({tag, ".stall"}, 32'(if_stall), 32'(stall));
    last_stall = stall;
    nxt = m;
    if (flush) nxt.valid = 0;
    else if (m.valid && !ex_ready) nxt = m;
    else if (hz) nxt.valid = 0;
    else begin
      nxt = ref_decode(if_instr, if_pc);
      nxt.valid = if_valid;
    end
    @(posedge clk);
    m = nxt;
    if (wb_we && wb_rd != 5'd0) rf[wb_rd] = wb_data;
    #1;
    check_pkt(tag);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_valid = 0; if_instr = 32'h0000_0013; if_pc = 32'd0;
    ex_ready = 1; ex_is_load = 0; ex_rd = 5'd0; flush = 0;
    wb_we = 0; wb_rd = 5'd0; wb_data = 32'd0;
  endtask

  initial begin
    logic [31:0] ins;
    logic [6:0]  op;
    rst = 1'b1;
    idle_inputs();
    // A hazard-shaped input while reset is held must not raise the stall.
    if_valid = 1; if_instr = 32'h0020_81B3; ex_is_load = 1; ex_rd = 5'd1;
    model_reset();
    #12;
    check_pkt("reset");
    chk("reset.stall", 32'(if_stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();

    // ADDI x1,x0,5
    if_valid = 1; if_instr = 32'h0050_0093; if_pc = 32'h100;
    step("addi");
    chk("addi.imm_k", id_imm, 32'd5);
    chk("addi.rd_k", 32'(id_rd), 32'd1);
    chk("addi.wr_k", 32'(id_reg_wr), 32'd1);

    // Writeback x1=5, x2=7, then ADD x3,x1,x2
    if_valid = 0; wb_we = 1; wb_rd = 5'd1; wb_data = 32'd5;
    step("wb_x1");
    wb_rd = 5'd2; wb_data = 32'd7;
    step("wb_x2");
    wb_we = 0; if_valid = 1; if_instr = 32'h0020_81B3; if_pc = 32'h104;
    step("add");
    chk("add.rs1_k", id_rs1_data, 32'd5);
    chk("add.rs2_k", id_rs2_data, 32'd7);
    wb_we = 1; wb_rd = 5'd2; wb_data = 32'd9; if_pc = 32'h108;
    step("bypass");
    chk("bypass.rs2_k", id_rs2_data, 32'd9);

    // Load-use hazard on x1
    wb_we = 0; ex_is_load = 1; ex_rd = 5'd1; if_pc = 32'h10C;
    step("hz");
    chk("hz.valid_k", 32'(id_valid), 32'd0);
    ex_is_load = 0;
    step("hz_release");
    chk("hz_release.valid_k", 32'(id_valid), 32'd1);

    // EX back-pressure, flushed in the second cycle
    ex_ready = 0; if_instr = 32'h00A0_0113; if_pc = 32'h110;
    step("bp1");
    chk("bp1.pc_k", id_pc, 32'h10C);
    flush = 1;
    step("bp_flush");
    chk("bp_flush.valid_k", 32'(id_valid), 32'd0);
    flush = 0;
    step("bp3");

    // Illegal opcode, then a write to x0 that must never be visible
    ex_ready = 1; if_instr = 32'h0002_9486; if_pc = 32'h200;
    step("illegal");
    chk("illegal.ill_k", 32'(id_illegal), 32'd1);
    chk("illegal.valid_k", 32'(id_valid), 32'd1);
    wb_we = 1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF; if_instr = 32'h0000_01B3; if_pc = 32'h204;
    step("x0_wb");
    chk("x0_wb.rs1_k", id_rs1_data, 32'd0);
    wb_we = 0;
    step("x0_read");
    chk("x0_read.rs1_k", id_rs1_data, 32'd0);

    // Asynchronous reset between clock edges with a valid packet present
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_pkt("arst");
    chk("arst.stall", 32'(if_stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    if_instr = 32'h0020_81B3; if_pc = 32'h300;
    step("post_rst");
    chk("post_rst.rs1_k", id_rs1_data, 32'd0);

    // Constrained-random traffic over a few registers to provoke hazards and bypasses
    for (int n = 0; n < 400; n++) begin
      if (!last_stall || flush) begin
        case ($urandom_range(0, 5))
          0: op = 7'b0110011;
          1: op = 7'b0010011;
          2: op = 7'b0000011;
          3: op = 7'b0100011;
          4: op = 7'b1100011;
          default: op = illegal_ops[$urandom_range(0, 3)];
        endcase
        ins = $urandom;
        ins[6:0] = op;
        ins[11:7] = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        if_instr = ins;
        if_pc = $urandom;
        if_valid = $urandom_range(0, 3) != 0;
      end
      ex_ready = $urandom_range(0, 3) != 0;
      ex_is_load = $urandom_range(0, 2) == 0;
      ex_rd = 5'($urandom_range(0, 3));
      flush = $urandom_range(0, 9) == 0;
      wb_we = $urandom_range(0, 1) == 1;
      wb_rd = 5'($urandom_range(0, 3));
      wb_data = $urandom;
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
